// File: rtl/pronoc_pkg.sv
// pronoc_pkg: shared tree-NoC address encoding, default flit field offsets and injector states
package pronoc_pkg;
    localparam int PFW = 32;
    localparam int PV = 2;
    localparam int VC_LSB = PFW;
    localparam int TAIL_BIT = PFW + PV;
    localparam int HDR_BIT = PFW + PV + 1;

    typedef enum logic [1:0] {IDLE, HEAD, BODY, DROP} inj_state_e;

    // {leaf port, base-K digits of leaf router position}, digit i at [i*kw +: kw]
    function automatic int tree_dest_encode(input int dst, input int k, input int kw, input int l);
        int pos = dst / k;
        int enc = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < l) begin
                enc |= (pos % k) << (i * kw);
                pos = pos / k;
            end
        end
        return enc | ((dst % k) << (l * kw));
    endfunction
endpackage

// File: rtl/tree_credit_counter.sv
// tree_credit_counter: per-VC credit up/down counter, saturating at B with sticky overflow flag
module tree_credit_counter #(
    parameter int B = 4,
    localparam int CW = $clog2(B + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          err
);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            count <= CW'(B);
            err <= 1'b0;
        end else if (inc && !dec) begin
            if (count == CW'(B)) err <= 1'b1;
            else count <= count + CW'(1);
        end else if (dec && !inc) begin
            count <= count - CW'(1);
        end
endmodule

// File: rtl/tree_endp_injector.sv
// tree_endp_injector: turns packet descriptors plus payload words into tree NoC
// header/body/tail flits for one endpoint, with per-VC credit flow control
module tree_endp_injector
    import pronoc_pkg::*;
#(
    parameter int ENDP_ID = 0,
    parameter int K = 2,
    parameter int L = 2,
    parameter int Fw = 32,
    parameter int V = 2,
    parameter int B = 4,
    parameter int MAX_PCK = 16,
    localparam int NE = K ** L,
    localparam int DW = $clog2(NE + 1),
    localparam int LW = $clog2(MAX_PCK + 1),
    localparam int VW = V > 1 ? $clog2(V) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pck_valid,
    output logic              pck_ready,
    input  logic [DW-1:0]     pck_dst,
    input  logic [LW-1:0]     pck_len,
    input  logic [VW-1:0]     pck_vc,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [Fw-1:0]     data,
    output logic [2+V+Fw-1:0] flit_out,
    output logic              flit_wr,
    input  logic [V-1:0]      credit_in,
    output logic              dst_err,
    output logic              credit_err,
    output logic [15:0]       pck_cnt
);
    localparam int KW = $clog2(K);
    localparam int EW = KW + L * KW;
    localparam int CW = $clog2(B + 1);
    localparam logic [EW-1:0] SRC = EW'(tree_dest_encode(ENDP_ID, K, KW, L));

    inj_state_e state;
    logic [DW-1:0] dst_q;
    logic [VW-1:0] vc_q;
    logic [LW-1:0] rem;
    logic [LW-1:0] len;
    logic [EW-1:0] dest;
    logic [CW-1:0] credit [V];
    logic [V-1:0] cred_err, send_v;
    logic cred_ok, accept, hs, send, is_head, bad_dst;

    assign len = pck_len == '0 ? LW'(1) : pck_len;
    assign bad_dst = int'(pck_dst) >= NE;
    assign dest = EW'(tree_dest_encode(int'(dst_q), K, KW, L));
    assign cred_ok = credit[vc_q] != '0;
    assign is_head = state == HEAD;
    assign pck_ready = state == IDLE && !reset;
    assign data_ready = (state == BODY && cred_ok) || state == DROP;
    assign accept = pck_valid && pck_ready;
    assign hs = data_valid && data_ready;
    assign send = (is_head && cred_ok) || (state == BODY && hs);
    assign send_v = send ? V'(1) << vc_q : '0;
    assign credit_err = |cred_err;

    for (genvar i = 0; i < V; i++) begin : g_cc
        tree_credit_counter #(.B(B)) u_cc (
            .clk  (clk),
            .reset(reset),
            .inc  (credit_in[i]),
            .dec  (send_v[i]),
            .count(credit[i]),
            .err  (cred_err[i])
        );
    end

    // rem counts body words still owed after the header
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            dst_q <= '0;
            vc_q <= '0;
            rem <= '0;
            flit_out <= '0;
            flit_wr <= 1'b0;
            dst_err <= 1'b0;
            pck_cnt <= '0;
        end else begin
            flit_wr <= send;
            if (send)
                flit_out <= {is_head, is_head ? rem == '0 : rem == LW'(1), send_v,
                             is_head ? Fw'({SRC, dest}) : data};
            case (state)
                IDLE: if (accept) begin
                    dst_q <= pck_dst;
                    vc_q <= pck_vc;
                    rem <= len - LW'(1);
                    state <= bad_dst ? DROP : HEAD;
                    dst_err <= dst_err | bad_dst;
                end
                HEAD: if (cred_ok) begin
                    state <= rem == '0 ? IDLE : BODY;
                    if (rem == '0) pck_cnt <= pck_cnt + 16'd1;
                end
                BODY: if (hs) begin
                    rem <= rem - LW'(1);
                    if (rem == LW'(1)) begin
                        state <= IDLE;
                        pck_cnt <= pck_cnt + 16'd1;
                    end
                end
                DROP: if (rem == '0) state <= IDLE;
                    else if (hs) begin
                        rem <= rem - LW'(1);
                        if (rem == LW'(1)) state <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_tree_endp_injector.sv
// tb_tree_endp_injector: directed scenarios for the tree endpoint injector (K=2, L=2, V=2, B=4)
module tb_tree_endp_injector;
    logic clk, reset, pck_valid, pck_ready, data_valid, data_ready, flit_wr;
    logic dst_err, credit_err;
    logic [2:0] pck_dst;
    logic [4:0] pck_len;
    logic [0:0] pck_vc;
    logic [31:0] data;
    logic [35:0] flit_out, exp_flit;
    logic [1:0] credit_in;
    logic [15:0] pck_cnt;
    int pass = 0, total = 0;

    tree_endp_injector dut (
        .clk(clk), .reset(reset), .pck_valid(pck_valid), .pck_ready(pck_ready),
        .pck_dst(pck_dst), .pck_len(pck_len), .pck_vc(pck_vc),
        .data_valid(data_valid), .data_ready(data_ready), .data(data),
        .flit_out(flit_out), .flit_wr(flit_wr), .credit_in(credit_in),
        .dst_err(dst_err), .credit_err(credit_err), .pck_cnt(pck_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input logic [2:0] d, input logic [4:0] n, input logic v);
        pck_valid = 1; pck_dst = d; pck_len = n; pck_vc = v;
        tick();
        pck_valid = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) tick();
        total++; if (pck_ready !== 1'b0) $display("FAIL reset_pck_ready: got %b expected 0", pck_ready); else pass++;
        total++; if (flit_wr !== 1'b0) $display("FAIL reset_flit_wr: got %b expected 0", flit_wr); else pass++;
        total++; if (flit_out !== 36'h0) $display("FAIL reset_flit_out: got %h expected 0", flit_out); else pass++;
        total++; if ({dst_err, credit_err, data_ready} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {dst_err, credit_err, data_ready}); else pass++;
        total++; if (pck_cnt !== 16'd0) $display("FAIL reset_pck_cnt: got %0d expected 0", pck_cnt); else pass++;
        total++; if (dut.credit[0] !== 3'd4 || dut.credit[1] !== 3'd4) $display("FAIL reset_credit: got %0d/%0d expected 4/4", dut.credit[0], dut.credit[1]); else pass++;
        reset = 0;
        #1;
        total++; if (pck_ready !== 1'b1) $display("FAIL release_pck_ready: got %b expected 1", pck_ready); else pass++;
    endtask

    task automatic test_single();
        send_desc(3'd3, 5'd1, 1'b1);
        total++; if (flit_wr !== 1'b0) $display("FAIL single_t1_wr: got %b expected 0", flit_wr); else pass++;
        tick();
        exp_flit = {1'b1, 1'b1, 2'b10, 32'h5};
        total++; if (flit_wr !== 1'b1) $display("FAIL single_t2_wr: got %b expected 1", flit_wr); else pass++;
        total++; if (flit_out !== exp_flit) $display("FAIL single_flit: got %h expected %h", flit_out, exp_flit); else pass++;
        tick();
        total++; if (pck_cnt !== 16'd1) $display("FAIL single_pck_cnt: got %0d expected 1", pck_cnt); else pass++;
        total++; if (dut.credit[1] !== 3'd3) $display("FAIL single_credit1: got %0d expected 3", dut.credit[1]); else pass++;
        total++; if (flit_wr !== 1'b0) $display("FAIL single_wr_drop: got %b expected 0", flit_wr); else pass++;
        credit_in = 2'b10;
        tick();
        credit_in = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        words = '{32'hA, 32'hB, 32'hC};
        send_desc(3'd2, 5'd4, 1'b0);
        tick();
        exp_flit = {1'b1, 1'b0, 2'b01, 32'h1};
        total++; if (flit_wr !== 1'b1 || flit_out !== exp_flit) $display("FAIL b2b_header: got %b/%h expected 1/%h", flit_wr, flit_out, exp_flit); else pass++;
        data_valid = 1;
        for (int i = 0; i < 3; i++) begin
            data = words[i];
            tick();
            exp_flit = {1'b0, i == 2, 2'b01, words[i]};
            total++; if (flit_wr !== 1'b1 || flit_out !== exp_flit) $display("FAIL b2b_body%0d: got %b/%h expected 1/%h", i, flit_wr, flit_out, exp_flit); else pass++;
        end
        data_valid = 0;
        total++; if (dut.credit[0] !== 3'd0) $display("FAIL b2b_credit0: got %0d expected 0", dut.credit[0]); else pass++;
        total++; if (pck_cnt !== 16'd2) $display("FAIL b2b_pck_cnt: got %0d expected 2", pck_cnt); else pass++;
        send_desc(3'd1, 5'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (flit_wr !== 1'b0) $display("FAIL stall_wr%0d: got %b expected 0", i, flit_wr); else pass++;
        end
        credit_in = 2'b01;
        tick();
        credit_in = 2'b00;
        total++; if (flit_wr !== 1'b0) $display("FAIL stall_p1_wr: got %b expected 0", flit_wr); else pass++;
        tick();
        exp_flit = {1'b1, 1'b0, 2'b01, 32'h4};
        total++; if (flit_wr !== 1'b1 || flit_out !== exp_flit) $display("FAIL stall_header: got %b/%h expected 1/%h", flit_wr, flit_out, exp_flit); else pass++;
        total++; if (data_ready !== 1'b0) $display("FAIL nocredit_data_ready: got %b expected 0", data_ready); else pass++;
        credit_in = 2'b01;
        tick();
        credit_in = 2'b00;
        data_valid = 1; data = 32'hD;
        tick();
        data_valid = 0;
        exp_flit = {1'b0, 1'b1, 2'b01, 32'hD};
        total++; if (flit_wr !== 1'b1 || flit_out !== exp_flit) $display("FAIL stall_tail: got %b/%h expected 1/%h", flit_wr, flit_out, exp_flit); else pass++;
        credit_in = 2'b01;
        repeat (4) tick();
        credit_in = 2'b00;
        total++; if (dut.credit[0] !== 3'd4 || credit_err !== 1'b0) $display("FAIL refill: got %0d/%b expected 4/0", dut.credit[0], credit_err); else pass++;
    endtask

    task automatic test_credit_boundary();
        credit_in = 2'b01;
        tick();
        credit_in = 2'b00;
        total++; if (credit_err !== 1'b1) $display("FAIL credit_err: got %b expected 1", credit_err); else pass++;
        total++; if (dut.credit[0] !== 3'd4) $display("FAIL credit_sat: got %0d expected 4", dut.credit[0]); else pass++;
        send_desc(3'd0, 5'd3, 1'b0);
        tick();
        data_valid = 1; data = 32'hE1;
        tick();
        data = 32'hE2; credit_in = 2'b01;
        tick();
        data_valid = 0; credit_in = 2'b00;
        total++; if (dut.credit[0] !== 3'd2) $display("FAIL credit_simul: got %0d expected 2", dut.credit[0]); else pass++;
        exp_flit = {1'b0, 1'b1, 2'b01, 32'hE2};
        total++; if (flit_out !== exp_flit || pck_cnt !== 16'd4) $display("FAIL simul_tail: got %h/%0d expected %h/4", flit_out, pck_cnt, exp_flit); else pass++;
        credit_in = 2'b01;
        repeat (2) tick();
        credit_in = 2'b00;
    endtask

    task automatic test_drop();
        int wr_seen = 0;
        send_desc(3'd5, 5'd3, 1'b1);
        total++; if (dst_err !== 1'b1) $display("FAIL drop_dst_err: got %b expected 1", dst_err); else pass++;
        total++; if (pck_ready !== 1'b0 || data_ready !== 1'b1) $display("FAIL drop_ready: got %b/%b expected 0/1", pck_ready, data_ready); else pass++;
        data_valid = 1; data = 32'hF;
        repeat (2) begin
            tick();
            wr_seen += int'(flit_wr);
        end
        data_valid = 0;
        total++; if (wr_seen !== 0) $display("FAIL drop_no_flit: got %0d expected 0", wr_seen); else pass++;
        total++; if (pck_ready !== 1'b1 || data_ready !== 1'b0) $display("FAIL drop_idle: got %b/%b expected 1/0", pck_ready, data_ready); else pass++;
        total++; if (pck_cnt !== 16'd4) $display("FAIL drop_pck_cnt: got %0d expected 4", pck_cnt); else pass++;
    endtask

    task automatic test_reset_mid();
        send_desc(3'd3, 5'd4, 1'b1);
        tick();
        total++; if (flit_wr !== 1'b1) $display("FAIL mid_header: got %b expected 1", flit_wr); else pass++;
        reset = 1; data_valid = 1; data = 32'h77;
        #1;
        total++; if ({flit_wr, dst_err, credit_err, pck_ready, data_ready} !== 5'b0 || flit_out !== 36'h0 || pck_cnt !== 16'd0)
            $display("FAIL mid_reset_outs: got %b/%h/%0d expected 00000/0/0", {flit_wr, dst_err, credit_err, pck_ready, data_ready}, flit_out, pck_cnt); else pass++;
        total++; if (dut.credit[1] !== 3'd4) $display("FAIL mid_reset_credit: got %0d expected 4", dut.credit[1]); else pass++;
        tick();
        data_valid = 0;
        reset = 0;
        #1;
        total++; if (pck_ready !== 1'b1) $display("FAIL mid_release_ready: got %b expected 1", pck_ready); else pass++;
        tick();
        total++; if (flit_wr !== 1'b0 || flit_out !== 36'h0) $display("FAIL mid_no_tail: got %b/%h expected 0/0", flit_wr, flit_out); else pass++;
    endtask

    task automatic test_len_zero();
        send_desc(3'd3, 5'd0, 1'b0);
        tick();
        exp_flit = {1'b1, 1'b1, 2'b01, 32'h5};
        total++; if (flit_wr !== 1'b1 || flit_out !== exp_flit) $display("FAIL len0_flit: got %b/%h expected 1/%h", flit_wr, flit_out, exp_flit); else pass++;
        tick();
        total++; if (pck_cnt !== 16'd1 || pck_ready !== 1'b1) $display("FAIL len0_done: got %0d/%b expected 1/1", pck_cnt, pck_ready); else pass++;
    endtask

    initial begin
        reset = 1; pck_valid = 0; pck_dst = 0; pck_len = 0; pck_vc = 0;
        data_valid = 0; data = 0; credit_in = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_credit_boundary();
        test_drop();
        test_reset_mid();
        test_len_zero();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
